// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: x - y - bin -> d with borrow bout.
module full_subtractor_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference bit and borrow-out of the single-bit cell
   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor: a - b - borrow_in over WIDTH clocks.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_e             state_q, state_d;
   logic               start_ready_q, start_ready_d;
   logic               done_valid_q, done_valid_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               brw_q, brw_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               borrow_out_q, borrow_out_d;

   logic               cell_d;
   logic               cell_bout;
   logic [WIDTH-1:0]   diff_shift;

   // Single shared cell operating on the current LSBs and the running borrow
   full_subtractor_cell u_cell (
      .x    (a_q[0]),
      .y    (b_q[0]),
      .bin  (brw_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   // New difference bit enters at the MSB so the LSB-first stream lands in order
   if (WIDTH == 1) begin : g_shift_w1
      assign diff_shift = cell_d;
   end else begin : g_shift_wn
      assign diff_shift = {cell_d, diff_q[WIDTH-1:1]};
   end

   // Next-state, datapath and handshake output logic
   always_comb begin
      state_d       = state_q;
      start_ready_d = start_ready_q;
      done_valid_d  = done_valid_q;
      a_d           = a_q;
      b_d           = b_q;
      brw_d         = brw_q;
      cnt_d         = cnt_q;
      diff_d        = diff_q;
      borrow_out_d  = borrow_out_q;

      case (state_q)
         IDLE: begin
            if (start_valid && start_ready_q) begin
               a_d           = a;
               b_d           = b;
               brw_d         = borrow_in;
               cnt_d         = '0;
               state_d       = RUN;
               start_ready_d = 1'b0;
            end
         end
         RUN: begin
            a_d    = a_q >> 1;
            b_d    = b_q >> 1;
            brw_d  = cell_bout;
            cnt_d  = cnt_q + CNT_W'(1);
            diff_d = diff_shift;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d      = DONE;
               done_valid_d = 1'b1;
               borrow_out_d = cell_bout;
            end
         end
         DONE: begin
            if (done_ready) begin
               state_d       = IDLE;
               done_valid_d  = 1'b0;
               start_ready_d = 1'b1;
            end
         end
         default: begin
            state_d       = IDLE;
            start_ready_d = 1'b1;
            done_valid_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         start_ready_q <= 1'b1;
         done_valid_q  <= 1'b0;
         a_q           <= '0;
         b_q           <= '0;
         brw_q         <= 1'b0;
         cnt_q         <= '0;
         diff_q        <= '0;
         borrow_out_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         start_ready_q <= start_ready_d;
         done_valid_q  <= done_valid_d;
         a_q           <= a_d;
         b_q           <= b_d;
         brw_q         <= brw_d;
         cnt_q         <= cnt_d;
         diff_q        <= diff_d;
         borrow_out_q  <= borrow_out_d;
      end
   end

   assign start_ready = start_ready_q;
   assign done_valid  = done_valid_q;
   assign diff        = diff_q;
   assign borrow_out  = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of the bit-serial subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       sv8 = 1'b0, sr8, bin8 = 1'b0, dv8, dr8 = 1'b1, bo8;
   logic [7:0] a8 = '0, b8 = '0, diff8;

   logic       sv1 = 1'b0, sr1, bin1 = 1'b0, dv1, dr1 = 1'b1, bo1;
   logic [0:0] a1 = '0, b1 = '0, diff1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n),
      .start_valid(sv8), .start_ready(sr8),
      .a(a8), .b(b8), .borrow_in(bin8),
      .done_valid(dv8), .done_ready(dr8),
      .diff(diff8), .borrow_out(bo8)
   );

   serial_subtractor #(.WIDTH(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .start_valid(sv1), .start_ready(sr1),
      .a(a1), .b(b1), .borrow_in(bin1),
      .done_valid(dv1), .done_ready(dr1),
      .diff(diff1), .borrow_out(bo1)
   );

   // Drive one WIDTH=8 operation; returns result sampled on the first done cycle
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input int hold, output logic [7:0] d, output logic bo,
                      output int lat);
      a8 = a; b8 = b; bin8 = bin; sv8 = 1'b1; dr8 = (hold == 0);
      @(posedge clk); #1;
      sv8 = 1'b0;
      lat = 0;
      while (!dv8 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      d = diff8; bo = bo8;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
      end
      dr8 = 1'b1;
      @(posedge clk); #1;
   endtask

   // Same for the WIDTH=1 instance
   task automatic op1(input logic a, input logic b, input logic bin,
                      output logic d, output logic bo, output int lat);
      a1 = a; b1 = b; bin1 = bin; sv1 = 1'b1; dr1 = 1'b1;
      @(posedge clk); #1;
      sv1 = 1'b0;
      lat = 0;
      while (!dv1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      d = diff1[0]; bo = bo1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      n_cmp++;
      if (sr8 !== 1'b1 || dv8 !== 1'b0 || diff8 !== 8'h00 || bo8 !== 1'b0) begin
         n_err++;
         $display("FAIL reset_w8: sr=%b dv=%b diff=%h bo=%b required 1 0 00 0", sr8, dv8, diff8, bo8);
      end
      n_cmp++;
      if (sr1 !== 1'b1 || dv1 !== 1'b0 || diff1 !== 1'b0 || bo1 !== 1'b0) begin
         n_err++;
         $display("FAIL reset_w1: sr=%b dv=%b diff=%b bo=%b required 1 0 0 0", sr1, dv1, diff1, bo1);
      end
   endtask

   task automatic test_basic;
      logic [7:0] d; logic bo; int lat;
      op8(8'h5A, 8'h23, 1'b0, 0, d, bo, lat);
      n_cmp++;
      if (d !== 8'h37 || bo !== 1'b0) begin
         n_err++; $display("FAIL basic_5a_23: got %h/%b required 37/0", d, bo);
      end
      n_cmp++;
      if (lat !== 8) begin
         n_err++; $display("FAIL latency: got %0d required 8", lat);
      end
      op8(8'h00, 8'h01, 1'b0, 0, d, bo, lat);
      n_cmp++;
      if (d !== 8'hFF || bo !== 1'b1) begin
         n_err++; $display("FAIL underflow_00_01: got %h/%b required ff/1", d, bo);
      end
   endtask

   task automatic test_borrow_in;
      logic [7:0] d; logic bo; int lat;
      op8(8'h10, 8'h0F, 1'b1, 0, d, bo, lat);
      n_cmp++;
      if (d !== 8'h00 || bo !== 1'b0) begin
         n_err++; $display("FAIL bin_10_0f: got %h/%b required 00/0", d, bo);
      end
      op8(8'h10, 8'h10, 1'b1, 0, d, bo, lat);
      n_cmp++;
      if (d !== 8'hFF || bo !== 1'b1) begin
         n_err++; $display("FAIL bin_10_10: got %h/%b required ff/1", d, bo);
      end
   endtask

   task automatic test_backpressure;
      logic [7:0] d; logic bo; int lat;
      a8 = 8'h5A; b8 = 8'h23; bin8 = 1'b0; sv8 = 1'b1; dr8 = 1'b0;
      @(posedge clk); #1;
      sv8 = 1'b0;
      lat = 0;
      while (!dv8 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      for (int i = 0; i < 5; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); sv8 = ~sv8;
         @(posedge clk); #1;
         n_cmp++;
         if (dv8 !== 1'b1 || diff8 !== 8'h37 || bo8 !== 1'b0 || sr8 !== 1'b0) begin
            n_err++;
            $display("FAIL hold_%0d: dv=%b diff=%h bo=%b sr=%b required 1 37 0 0", i, dv8, diff8, bo8, sr8);
         end
      end
      // Release together with a start request: the start must not be taken in DONE
      sv8 = 1'b1; dr8 = 1'b1;
      @(posedge clk); #1;
      sv8 = 1'b0;
      n_cmp++;
      if (dv8 !== 1'b0 || sr8 !== 1'b1) begin
         n_err++; $display("FAIL release: dv=%b sr=%b required 0 1", dv8, sr8);
      end
      op8(8'h33, 8'h11, 1'b0, 0, d, bo, lat);
      n_cmp++;
      if (d !== 8'h22 || bo !== 1'b0 || lat !== 8) begin
         n_err++; $display("FAIL after_release: got %h/%b lat %0d required 22/0 lat 8", d, bo, lat);
      end
   endtask

   task automatic test_reset_mid_run;
      logic [7:0] d; logic bo; int lat;
      a8 = 8'h5A; b8 = 8'h23; bin8 = 1'b0; sv8 = 1'b1; dr8 = 1'b1;
      @(posedge clk); #1;
      sv8 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (sr8 !== 1'b1 || dv8 !== 1'b0 || diff8 !== 8'h00 || bo8 !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_run: sr=%b dv=%b diff=%h bo=%b required 1 0 00 0", sr8, dv8, diff8, bo8);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (sr8 !== 1'b1 || dv8 !== 1'b0) begin
         n_err++; $display("FAIL post_reset: sr=%b dv=%b required 1 0", sr8, dv8);
      end
      op8(8'hFF, 8'h01, 1'b0, 0, d, bo, lat);
      n_cmp++;
      if (d !== 8'hFE || bo !== 1'b0) begin
         n_err++; $display("FAIL ff_minus_01: got %h/%b required fe/0", d, bo);
      end
   endtask

   task automatic test_width1;
      logic d; logic bo; int lat; int r;
      logic [2:0] v;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         op1(v[2], v[1], v[0], d, bo, lat);
         r = int'(v[2]) - int'(v[1]) - int'(v[0]);
         n_cmp++;
         if (d !== r[0] || bo !== (r < 0) || lat !== 1) begin
            n_err++;
            $display("FAIL w1_x%0d_y%0d_b%0d: got d=%b bo=%b lat=%0d required d=%b bo=%b lat=1",
                     v[2], v[1], v[0], d, bo, lat, r[0], (r < 0));
         end
      end
   endtask

   task automatic test_random;
      logic [7:0] a, b, d; logic bin, bo; int lat;
      logic [8:0] ref9;
      for (int i = 0; i < 300; i++) begin
         a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
         op8(a, b, bin, int'($urandom_range(0, 3)), d, bo, lat);
         ref9 = {1'b0, a} - {1'b0, b} - {8'h00, bin};
         n_cmp++;
         if (d !== ref9[7:0] || bo !== ref9[8] || lat !== 8) begin
            n_err++;
            $display("FAIL rand_%0d: %h-%h-%b got %h/%b lat %0d required %h/%b lat 8",
                     i, a, b, bin, d, bo, lat, ref9[7:0], ref9[8]);
         end
      end
   endtask

   initial begin
      #12 rst_n = 1'b0;
      #1;
      test_reset;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      test_basic;
      test_borrow_in;
      test_backpressure;
      test_reset_mid_run;
      test_width1;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
